// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: FSM state encoding and line levels.
// Used by both the transmitter and the receiver.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_done on the last count.
// clear forces the count back to 0 so the next period starts cleanly.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [TW-1:0] r_count;

    assign bit_done = (r_count == TW'(CLKS_PER_BIT - 1));

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear || bit_done) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + TW'(1);
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, DATA_W data bits LSB-first, stop bit.
// Define PARITY_EN to insert an even-parity bit between the data and stop bits.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy
);

    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            r_state, w_state_next;
    logic [DATA_W-1:0] r_shift, w_shift_next;
    logic [IW-1:0]     r_bit_idx, w_bit_idx_next;
    logic              r_tx_out, w_tx_out_next;
    logic              w_bit_done;
    logic              w_timer_clear;
`ifdef PARITY_EN
    logic              r_parity, w_parity_next;
`endif

    // Held in clear while idle so the START period begins at count 0.
    assign w_timer_clear = (r_state == IDLE);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_timer_clear),
        .bit_done(w_bit_done)
    );

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
`ifdef PARITY_EN
        w_parity_next  = r_parity;
`endif
        case (r_state)
            IDLE: begin
                if (tx_valid) begin
                    w_state_next   = START;
                    w_shift_next   = tx_data;
                    w_bit_idx_next = '0;
`ifdef PARITY_EN
                    w_parity_next  = ^tx_data;
`endif
                end
            end
            START: begin
                if (w_bit_done) w_state_next = DATA;
            end
            DATA: begin
                if (w_bit_done) begin
                    if (r_bit_idx == IW'(DATA_W - 1)) begin
`ifdef PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end else begin
                        w_shift_next   = r_shift >> 1;
                        w_bit_idx_next = r_bit_idx + IW'(1);
                    end
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (w_bit_done) w_state_next = STOP;
            end
`endif
            STOP: begin
                if (w_bit_done) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase

        // Line level is decoded from the next state so the registered output lines up with it.
        case (w_state_next)
            START:   w_tx_out_next = START_LEVEL;
            DATA:    w_tx_out_next = w_shift_next[0];
`ifdef PARITY_EN
            PARITY:  w_tx_out_next = w_parity_next;
`endif
            default: w_tx_out_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx_out  <= LINE_IDLE;
`ifdef PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_idx <= w_bit_idx_next;
            r_tx_out  <= w_tx_out_next;
`ifdef PARITY_EN
            r_parity  <= w_parity_next;
`endif
        end
    end

    assign tx_out   = r_tx_out;
    assign tx_ready = (r_state == IDLE);
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: reset, single frame, back-to-back, busy-ignore,
// parity frames and mid-frame reset. Define PARITY_EN to run with parity at one clock per bit.
module tb_serial_tx;

    localparam int DATA_W = 8;
`ifdef PARITY_EN
    localparam int CPB    = 1;
    localparam int NBITS  = 11;
`else
    localparam int CPB    = 4;
    localparam int NBITS  = 10;
`endif

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic [DATA_W-1:0] tx_data  = '0;
    logic              tx_valid = 1'b0;
    logic              tx_ready;
    logic              tx_out;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    serial_tx #(
        .DATA_W      (DATA_W),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_out  (tx_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame bit b: 0 = start, 1..8 = data LSB-first, 9 = parity (if enabled), last = stop.
    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (NBITS == 11 && b == 9) return ^d;
        return 1'b1;
    endfunction

    // Called on the first cycle after the handshake edge; ends on the first idle cycle.
    task automatic expect_frame(input string tag, input logic [7:0] d,
                                input int poke_cycle, input logic [7:0] poke_data,
                                input bit poke_valid);
        for (int c = 0; c < NBITS * CPB; c++) begin
            check($sformatf("%s tx_out c%0d", tag, c), {31'd0, tx_out}, {31'd0, exp_bit(d, c / CPB)});
            check($sformatf("%s busy c%0d", tag, c), {31'd0, busy}, 32'd1);
            check($sformatf("%s ready c%0d", tag, c), {31'd0, tx_ready}, 32'd0);
            if (c == poke_cycle) begin
                tx_data = poke_data;
                if (poke_valid) tx_valid = 1'b1;
            end else if (poke_valid && c == poke_cycle + 1) begin
                tx_valid = 1'b0;
            end
            tick();
        end
        check($sformatf("%s idle tx_out", tag), {31'd0, tx_out}, 32'd1);
        check($sformatf("%s idle busy", tag), {31'd0, busy}, 32'd0);
        check($sformatf("%s idle ready", tag), {31'd0, tx_ready}, 32'd1);
    endtask

    task automatic send(input string tag, input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        expect_frame(tag, d, -1, 8'h00, 1'b0);
    endtask

    task automatic quiet(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            check($sformatf("%s quiet tx_out c%0d", tag, c), {31'd0, tx_out}, 32'd1);
            check($sformatf("%s quiet busy c%0d", tag, c), {31'd0, busy}, 32'd0);
            tick();
        end
    endtask

    task automatic reset_mid(input string tag, input logic [7:0] d, input int b);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int c = 0; c < (1 + b) * CPB; c++) tick();
        check($sformatf("%s pre tx_out", tag), {31'd0, tx_out}, {31'd0, d[b]});
        check($sformatf("%s pre busy", tag), {31'd0, busy}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check($sformatf("%s rst tx_out", tag), {31'd0, tx_out}, 32'd1);
        check($sformatf("%s rst busy", tag), {31'd0, busy}, 32'd0);
        check($sformatf("%s rst ready", tag), {31'd0, tx_ready}, 32'd1);
        tick();
        tick();
        reset = 1'b1;
        quiet(tag, 2 * NBITS * CPB);
    endtask

    initial begin
        // Reset held with a word offered: nothing may start.
        reset    = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset tx_out %0d", i), {31'd0, tx_out}, 32'd1);
            check($sformatf("reset busy %0d", i), {31'd0, busy}, 32'd0);
            check($sformatf("reset ready %0d", i), {31'd0, tx_ready}, 32'd1);
        end
        reset = 1'b1;
        #1;
        check("release busy", {31'd0, busy}, 32'd0);
        check("release tx_out", {31'd0, tx_out}, 32'd1);
        tick();
        tx_valid = 1'b0;
        expect_frame("post_reset FF", 8'hFF, -1, 8'h00, 1'b0);
        quiet("post_reset", 3);

        send("single A5", 8'hA5);
        quiet("single", 3);

        // Back-to-back with tx_valid held; tx_data changes right after acceptance.
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        tick();
        expect_frame("b2b 01", 8'h01, 0, 8'h80, 1'b0);
        tick();
        tx_valid = 1'b0;
        expect_frame("b2b 80", 8'h80, -1, 8'h00, 1'b0);
        quiet("b2b", 3);

        // A word offered mid-frame must be dropped.
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        expect_frame("ignore A5", 8'hA5, 3 * CPB, 8'h3C, 1'b1);
        quiet("ignore", 2 * NBITS * CPB);

        send("parity 07", 8'h07);
        quiet("parity07", 2);
        send("parity A5", 8'hA5);
        quiet("parityA5", 2);

        reset_mid("rst bit3 0F", 8'h0F, 3);
        reset_mid("rst bit4 0F", 8'h0F, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
